mem_bus_arbiter: RTL and testbench

- Shares the single memory bus between the instruction-fetch port and the load/store data port of the MIPS core.
- The data port is driven by the decoder's load/bus_write strobes.
- Arbitrates requests with a small FSM, drives one memory transaction at a time and waits for the memory's ready handshake.
- Returns read data or an error to the winning requester and generates the pipeline stall for data accesses.

---
 rtl/mem_bus_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory bus between the instruction-fetch port (if_*) and the
//   load/store data port (d_*). One transaction is in flight at a time. The
//   data port normally wins arbitration. The winner gets a one-cycle done
//   pulse carrying read data, or err if the memory never answered.
//
//   Handshake: a requester raises x_req (level) with stable address/data and
//   holds it until its x_done pulse. The arbiter raises mem_req in the cycle
//   after the grant and holds mem_req and the bus fields stable until
//   mem_ready is sampled high, or until the timeout aborts the access.
//   mem_ready is only looked at while a transaction is in flight.
//
//   Optional build macro: FETCH_STARVE_GUARD_EN. It adds a saturating count
//   of data grants made while fetch is waiting. When the count reaches
//   STARVE_LIMIT, the next arbitration goes to fetch.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   if_req/if_addr      fetch request and address
//   if_rdata/if_done    fetched word and completion pulse
//   d_req/d_we/d_addr/d_wdata   data request: store when d_we=1
//   d_rdata/d_done      load data and completion pulse
//   err                 accompanies a done pulse when the access timed out
//   stall               combinational: d_req & ~d_done
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready  memory bus
//   dbg_state           FSM state: 0 IDLE, 1 BUSY_I, 2 BUSY_D, 3 DONE
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
`ifdef FETCH_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The counter only has to hold 0..TIMEOUT-1; the abort fires when the
  // cycle that would make it TIMEOUT ends without mem_ready.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [DATA_W-1:0]   r_if_rdata, w_if_rdata_nxt;
  logic [DATA_W-1:0]   r_d_rdata, w_d_rdata_nxt;
  logic                r_if_done, w_if_done_nxt;
  logic                r_d_done, w_d_done_nxt;
  logic                r_err, w_err_nxt;
  logic                w_pick_d;
  logic                w_timeout;

`ifdef FETCH_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;
  logic          w_starve_full;

  assign w_starve_full = (r_starve == SW'(STARVE_LIMIT));
  // Once fetch has been passed over STARVE_LIMIT times, it goes ahead of data.
  assign w_pick_d = d_req & ~(if_req & w_starve_full);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_pick_d) begin
        if (if_req && !w_starve_full) r_starve <= r_starve + SW'(1);
      end else if (if_req) begin
        r_starve <= '0;
      end
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = '0;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_if_done_nxt   = 1'b0;
    w_d_done_nxt    = 1'b0;
    w_err_nxt       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_d) begin
          w_state_nxt     = ST_BUSY_D;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = d_we;
          w_mem_addr_nxt  = d_addr;
          w_mem_wdata_nxt = d_wdata;
        end else if (if_req) begin
          w_state_nxt    = ST_BUSY_I;
          w_mem_req_nxt  = 1'b1;
          w_mem_we_nxt   = 1'b0;
          w_mem_addr_nxt = if_addr;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // mem_ready takes precedence over an abort in the same cycle.
        if (mem_ready) begin
          w_state_nxt   = ST_DONE;
          w_cnt_nxt     = '0;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          if (r_state == ST_BUSY_D) begin
            w_d_rdata_nxt = mem_rdata;
            w_d_done_nxt  = 1'b1;
          end else begin
            w_if_rdata_nxt = mem_rdata;
            w_if_done_nxt  = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt   = ST_DONE;
          w_cnt_nxt     = '0;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_err_nxt     = 1'b1;
          if (r_state == ST_BUSY_D) begin
            w_d_rdata_nxt = '0;
            w_d_done_nxt  = 1'b1;
          end else begin
            w_if_rdata_nxt = '0;
            w_if_done_nxt  = 1'b1;
          end
        end
      end
      // The done pulse is visible here. Requests are not sampled, so the
      // requester has one cycle to drop or replace its request.
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_if_done   <= w_if_done_nxt;
      r_d_done    <= w_d_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign err       = r_err;
  assign stall     = d_req & ~r_d_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 3;
  localparam int SL = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BI   = 2'd1;
  localparam logic [1:0] S_BD   = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_req, d_we, mem_ready;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_done, d_done, err, stall, mem_req, mem_we;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  // Completion record: {if_done, d_done, err, rdata}
  logic [DW+2:0] exp_q[$];

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- memory driver ----------------
  // Called in the first BUSY cycle. mem_ready rises lat cycles later and is
  // held until a done pulse appears or the cycle budget runs out.
  task automatic drive_mem(input int lat, input logic [DW-1:0] word,
                           output int steps, output logic [DW+2:0] got,
                           output int drops);
    steps = 0; got = '0; drops = 0;
    mem_rdata = word;
    for (int c = 0; c < 12; c++) begin
      mem_ready = (c >= lat);
      step();
      steps++;
      if (if_done || d_done) begin
        got = {if_done, d_done, err, d_done ? d_rdata : if_rdata};
        break;
      end
      if (!mem_req) drops++;
    end
    mem_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    n_cmp++; if ({if_done, d_done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got=%b exp=000", {if_done, d_done, err}); end
    n_cmp++; if ({if_rdata, d_rdata} !== '0) begin n_bad++; $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, d_rdata); end
    n_cmp++; if ({mem_addr, mem_wdata} !== '0) begin n_bad++; $display("FAIL reset_bus got=%h/%h exp=0", mem_addr, mem_wdata); end
    n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
  endtask

  task automatic test_load();
    int steps, drops;
    logic [DW+2:0] got, exp;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = 32'h0;
    exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h1234ABCD});
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL load_stall_req got=%b exp=1", stall); end
    step();
    n_cmp++; if ({mem_req, mem_we, dbg_state} !== {1'b1, 1'b0, S_BD}) begin n_bad++; $display("FAIL load_start got=%b exp=%b", {mem_req, mem_we, dbg_state}, {1'b1, 1'b0, S_BD}); end
    n_cmp++; if (mem_addr !== 32'h40) begin n_bad++; $display("FAIL load_addr got=%h exp=40", mem_addr); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL load_stall_busy got=%b exp=1", stall); end
    drive_mem(2, 32'h1234ABCD, steps, got, drops);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL load_done got=%h exp=%h", got, exp); end
    n_cmp++; if (steps !== 3) begin n_bad++; $display("FAIL load_latency got=%0d exp=3", steps); end
    n_cmp++; if ({stall, mem_req, drops} !== {1'b0, 1'b0, 32'd0}) begin n_bad++; $display("FAIL load_end got stall=%b req=%b drops=%0d exp=0/0/0", stall, mem_req, drops); end
    d_req = 1'b0;
    step();
    n_cmp++; if ({d_done, dbg_state} !== {1'b0, S_IDLE}) begin n_bad++; $display("FAIL load_pulse_width got=%b exp=%b", {d_done, dbg_state}, {1'b0, S_IDLE}); end
  endtask

  task automatic test_store();
    int steps, drops;
    logic [DW+2:0] got;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    step();
    n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF}) begin n_bad++; $display("FAIL store_bus got=%b%b %h %h exp=11 100 deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
    // The requester changes its fields mid-access; the bus must not follow.
    d_addr = 32'h0; d_wdata = 32'h0; mem_ready = 1'b0;
    step();
    n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF}) begin n_bad++; $display("FAIL store_hold got=%b%b %h %h exp=11 100 deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
    drive_mem(0, 32'h55AA55AA, steps, got, drops);
    n_cmp++; if (got !== {1'b0, 1'b1, 1'b0, 32'h55AA55AA}) begin n_bad++; $display("FAIL store_done got=%h exp=%h", got, {1'b0, 1'b1, 1'b0, 32'h55AA55AA}); end
    n_cmp++; if ({steps, mem_we, mem_req} !== {32'd1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL store_end got steps=%0d we=%b req=%b exp=1/0/0", steps, mem_we, mem_req); end
    d_req = 1'b0; d_we = 1'b0;
    step();
  endtask

  task automatic test_both();
    int steps, drops;
    logic [DW+2:0] got;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    if_req = 1'b1; if_addr = 32'h1000;
    step();
    n_cmp++; if ({dbg_state, mem_addr} !== {S_BD, 32'h80}) begin n_bad++; $display("FAIL both_first got=%0d %h exp=2 80", dbg_state, mem_addr); end
    drive_mem(0, 32'hA1, steps, got, drops);
    n_cmp++; if (got !== {1'b0, 1'b1, 1'b0, 32'hA1}) begin n_bad++; $display("FAIL both_d_done got=%h exp=%h", got, {1'b0, 1'b1, 1'b0, 32'hA1}); end
    d_req = 1'b0;
    step();
    n_cmp++; if ({dbg_state, mem_req, if_done} !== {S_IDLE, 1'b0, 1'b0}) begin n_bad++; $display("FAIL both_idle got=%b exp=%b", {dbg_state, mem_req, if_done}, {S_IDLE, 2'b00}); end
    step();
    n_cmp++; if ({dbg_state, mem_we, mem_addr} !== {S_BI, 1'b0, 32'h1000}) begin n_bad++; $display("FAIL both_second got=%0d %b %h exp=1 0 1000", dbg_state, mem_we, mem_addr); end
    drive_mem(1, 32'hB2, steps, got, drops);
    n_cmp++; if ({got, steps} !== {1'b1, 1'b0, 1'b0, 32'hB2, 32'd2}) begin n_bad++; $display("FAIL both_if_done got=%h steps=%0d exp=%h steps=2", got, steps, {1'b1, 1'b0, 1'b0, 32'hB2}); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int steps, drops;
    logic [DW+2:0] got;
    if_req = 1'b1; if_addr = 32'h200;
    step();
    drive_mem(100, 32'h77, steps, got, drops);
    n_cmp++; if (got !== {1'b1, 1'b0, 1'b1, 32'h0}) begin n_bad++; $display("FAIL timeout_done got=%h exp=%h", got, {1'b1, 1'b0, 1'b1, 32'h0}); end
    n_cmp++; if ({steps, drops} !== {TO, 32'd0}) begin n_bad++; $display("FAIL timeout_len got steps=%0d drops=%0d exp=%0d/0", steps, drops, TO); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL timeout_req got=%b exp=0", mem_req); end
    if_req = 1'b0;
    step();
    n_cmp++; if ({err, if_done} !== 2'b00) begin n_bad++; $display("FAIL timeout_clear got=%b exp=00", {err, if_done}); end
  endtask

  task automatic test_reset_mid_busy();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h1;
    step();
    step();
    n_cmp++; if ({mem_req, dbg_state} !== {1'b1, S_BD}) begin n_bad++; $display("FAIL midrst_busy got=%b exp=%b", {mem_req, dbg_state}, {1'b1, S_BD}); end
    rst_n = 1'b0;
    step();
    n_cmp++; if ({mem_req, mem_we, d_done, err, dbg_state} !== {4'b0000, S_IDLE}) begin n_bad++; $display("FAIL midrst_abort got=%b exp=%b", {mem_req, mem_we, d_done, err, dbg_state}, {4'b0000, S_IDLE}); end
    rst_n = 1'b1; d_req = 1'b0; d_we = 1'b0;
    step();
    n_cmp++; if ({d_done, mem_req} !== 2'b00) begin n_bad++; $display("FAIL midrst_after got=%b exp=00", {d_done, mem_req}); end
  endtask

  task automatic test_starve();
    int steps, drops;
    logic [DW+2:0] got;
    logic want_fetch;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    if_req = 1'b1; if_addr = 32'h600;
    for (int g = 1; g <= SL + 1; g++) begin
`ifdef FETCH_STARVE_GUARD_EN
      want_fetch = (g == SL + 1);
`else
      want_fetch = 1'b0;
`endif
      step();
      n_cmp++; if (dbg_state !== (want_fetch ? S_BI : S_BD)) begin n_bad++; $display("FAIL starve_grant%0d got=%0d exp=%0d", g, dbg_state, want_fetch ? S_BI : S_BD); end
      drive_mem(0, DW'(g), steps, got, drops);
      n_cmp++; if (got !== {want_fetch, ~want_fetch, 1'b0, DW'(g)}) begin n_bad++; $display("FAIL starve_done%0d got=%h exp=%h", g, got, {want_fetch, ~want_fetch, 1'b0, DW'(g)}); end
      if (want_fetch) if_req = 1'b0;
      step();
    end
    d_req = 1'b0; if_req = 1'b0;
    step();
    step();
  endtask

  // Random traffic against a transaction-level model: each grant goes to
  // data when it is pending (subject to the starve guard), and completes
  // with the memory word if the memory answers within TO cycles, else with
  // err and zero data.
  task automatic test_random();
    logic          pend_i, pend_d, we_d, win_d;
    logic [AW-1:0] a_i, a_d;
    logic [DW-1:0] wd, word;
    logic [DW+2:0] got, exp;
    int            lat, steps, drops, scnt, exp_steps;
    do_reset();
    pend_i = 1'b0; pend_d = 1'b0; we_d = 1'b0; a_i = '0; a_d = '0; wd = '0; scnt = 0;
    for (int it = 0; it < 40; it++) begin
      if (!pend_d && ($urandom_range(0, 1) == 1)) begin
        pend_d = 1'b1; a_d = $urandom; wd = $urandom; we_d = 1'($urandom_range(0, 1));
      end
      if (!pend_i && ($urandom_range(0, 1) == 1)) begin
        pend_i = 1'b1; a_i = $urandom;
      end
      if (!pend_i && !pend_d) begin
        pend_i = 1'b1; a_i = $urandom;
      end
      d_req = pend_d; d_we = we_d; d_addr = a_d; d_wdata = wd;
      if_req = pend_i; if_addr = a_i;
      win_d = pend_d;
`ifdef FETCH_STARVE_GUARD_EN
      if (pend_i && scnt == SL) win_d = 1'b0;
      if (win_d && pend_i) scnt = (scnt < SL) ? scnt + 1 : SL;
      if (!win_d) scnt = 0;
`endif
      lat = $urandom_range(0, TO + 1);
      word = $urandom;
      exp_q.push_back({~win_d, win_d, (lat >= TO), (lat >= TO) ? 32'h0 : word});
      exp_steps = (lat >= TO) ? TO : lat + 1;
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      n_cmp++; if (stall !== pend_d) begin n_bad++; $display("FAIL rnd%0d_stall_idle got=%b exp=%b", it, stall, pend_d); end
      step();
      mem_ready = 1'b0;
      n_cmp++; if ({dbg_state, mem_req} !== {(win_d ? S_BD : S_BI), 1'b1}) begin n_bad++; $display("FAIL rnd%0d_grant got=%b exp=%b", it, {dbg_state, mem_req}, {(win_d ? S_BD : S_BI), 1'b1}); end
      n_cmp++; if ({mem_we, mem_addr} !== {win_d & we_d, win_d ? a_d : a_i}) begin n_bad++; $display("FAIL rnd%0d_bus got=%b %h exp=%b %h", it, mem_we, mem_addr, win_d & we_d, win_d ? a_d : a_i); end
      if (win_d && we_d) begin
        n_cmp++; if (mem_wdata !== wd) begin n_bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", it, mem_wdata, wd); end
      end
      drive_mem(lat, word, steps, got, drops);
      exp = exp_q.pop_front();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rnd%0d_done got=%h exp=%h", it, got, exp); end
      n_cmp++; if ({steps, drops} !== {exp_steps, 32'd0}) begin n_bad++; $display("FAIL rnd%0d_timing got steps=%0d drops=%0d exp=%0d/0", it, steps, drops, exp_steps); end
      n_cmp++; if (stall !== (pend_d & ~win_d)) begin n_bad++; $display("FAIL rnd%0d_stall_done got=%b exp=%b", it, stall, pend_d & ~win_d); end
      if (win_d) pend_d = 1'b0; else pend_i = 1'b0;
      d_req = pend_d; if_req = pend_i;
      mem_ready = 1'($urandom_range(0, 1));
      step();
      mem_ready = 1'b0;
      n_cmp++; if ({if_done, d_done, err, mem_req, dbg_state} !== {4'b0000, S_IDLE}) begin n_bad++; $display("FAIL rnd%0d_back_idle got=%b exp=%b", it, {if_done, d_done, err, mem_req, dbg_state}, {4'b0000, S_IDLE}); end
    end
    d_req = 1'b0; if_req = 1'b0;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load();
    test_store();
    test_both();
    test_timeout();
    test_reset_mid_busy();
    test_starve();
    test_random();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
